// File: rtl/rf_write_arb.sv
// Two-port write arbiter for an 8 x 16-bit register file, with a sequential clear engine.
// It also drives the one-hot read-port output enables and flags read-during-write hazards.
module rf_write_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [2:0]  addr0,
    input  logic [15:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [2:0]  addr1,
    input  logic [15:0] data1,
    output logic        ack1,
    input  logic        clr,
    input  logic [2:0]  selA,
    input  logic [2:0]  selB,
    input  logic        rdA_en,
    input  logic        rdB_en,
    output logic [7:0]  ld,
    output logic [15:0] din,
    output logic [7:0]  oeA,
    output logic [7:0]  oeB,
    output logic        hazA,
    output logic        hazB,
    output logic        busy,
    output logic        clr_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;          // 1: port 1 wins the next tie
    logic        wv_q, wv_d;
    logic [2:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [2:0]  clr_idx_q, clr_idx_d;
    logic        clr_done_q, clr_done_d;
    logic [15:0] din_hold_q, din_hold_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            wv_q       <= 1'b0;
            waddr_q    <= 3'd0;
            wdata_q    <= 16'd0;
            clr_idx_q  <= 3'd0;
            clr_done_q <= 1'b0;
            din_hold_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wv_q       <= wv_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            clr_idx_q  <= clr_idx_d;
            clr_done_q <= clr_done_d;
            din_hold_q <= din_hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wv_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        clr_idx_d  = clr_idx_q;
        clr_done_d = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;

        case (state_q)
            IDLE: begin
                ack0 = req0 & (~req1 | ~ptr_q);
                ack1 = req1 & (~req0 | ptr_q);
                if (ack0) begin
                    wv_d    = 1'b1;
                    waddr_d = addr0;
                    wdata_d = data0;
                    ptr_d   = 1'b1;
                end else if (ack1) begin
                    wv_d    = 1'b1;
                    waddr_d = addr1;
                    wdata_d = data1;
                    ptr_d   = 1'b0;
                end
                if (clr) begin
                    state_d   = CLEAR;
                    clr_idx_d = 3'd0;
                end
            end
            CLEAR: begin
                // A write accepted on the clr edge drains first; the walk waits for it.
                if (!wv_q) begin
                    if (clr_idx_q == 3'd7) begin
                        state_d    = IDLE;
                        clr_idx_d  = 3'd0;
                        clr_done_d = 1'b1;
                    end else begin
                        clr_idx_d = clr_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            ack0 = 1'b0;
            ack1 = 1'b0;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_done = clr_done_q;

    // Write data wins over the clear pattern; otherwise din keeps its last driven value.
    assign din        = wv_q ? wdata_q : (busy ? 16'h0000 : din_hold_q);
    assign din_hold_d = din;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            assign ld[gi]  = (wv_q && (waddr_q == 3'(gi)))
                           || (busy && !wv_q && (clr_idx_q == 3'(gi)));
            assign oeA[gi] = ~reset & rdA_en & (selA == 3'(gi));
            assign oeB[gi] = ~reset & rdB_en & (selB == 3'(gi));
        end
    endgenerate

    assign hazA = ~reset & rdA_en & ld[selA];
    assign hazB = ~reset & rdB_en & ld[selB];

endmodule

// File: tb/tb_rf_write_arb.sv
// Directed bench for rf_write_arb: arbitration, write latency, clear walk, hazards and reset abort.
module tb_rf_write_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, clr, rdA_en, rdB_en;
    logic [2:0]  addr0, addr1, selA, selB;
    logic [15:0] data0, data1;
    logic        ack0, ack1, hazA, hazB, busy, clr_done;
    logic [7:0]  ld, oeA, oeB;
    logic [15:0] din;

    int n_tests = 0;
    int n_fail  = 0;

    rf_write_arb dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
        .clr(clr), .selA(selA), .selB(selB), .rdA_en(rdA_en), .rdB_en(rdB_en),
        .ld(ld), .din(din), .oeA(oeA), .oeB(oeB), .hazA(hazA), .hazB(hazB),
        .busy(busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0;
        req0 = 1'b1; addr0 = 3'd0; data0 = 16'h0;
        req1 = 1'b0; addr1 = 3'd0; data1 = 16'h0;
        selA = 3'd2; rdA_en = 1'b1; selB = 3'd0; rdB_en = 1'b0;
        #2;
        check("rst_ack0", ack0, 1'b0);
        check("rst_ld", ld, 8'h00);
        check("rst_din", din, 16'h0);
        check("rst_oeA", oeA, 8'h00);
        check("rst_hazA", hazA, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", clr_done, 1'b0);
        tick();
        tick();
        reset = 1'b0; req0 = 1'b0; rdA_en = 1'b0;

        // single request, same-cycle grant, ld one cycle later
        req0 = 1'b1; addr0 = 3'd3; data0 = 16'hBEEF;
        #1;
        $display("[TB] txn single req0 addr=3 data=beef");
        check("s_ack0", ack0, 1'b1);
        check("s_ack1", ack1, 1'b0);
        check("s_ld_pre", ld, 8'h00);
        tick();
        req0 = 1'b0;
        #1;
        check("s_ld", ld, 8'h08);
        check("s_din", din, 16'hBEEF);
        check("s_ack0_off", ack0, 1'b0);
        tick();
        check("s_ld_off", ld, 8'h00);
        check("s_din_hold", din, 16'hBEEF);

        // single req1 to put the pointer back on port 0
        req1 = 1'b1; addr1 = 3'd6; data1 = 16'h1234;
        #1;
        $display("[TB] txn single req1 addr=6 data=1234");
        check("r1_ack1", ack1, 1'b1);
        tick();
        req1 = 1'b0;
        #1;
        check("r1_ld", ld, 8'h40);
        check("r1_din", din, 16'h1234);
        tick();

        // both requests held: 0,1,0,1 with back-to-back ld pulses
        req0 = 1'b1; addr0 = 3'd1; req1 = 1'b1; addr1 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            data0 = 16'hA000 + 16'(i);
            data1 = 16'hB000 + 16'(i);
            #1;
            $display("[TB] txn rr cycle %0d", i);
            check("rr_ack0", ack0, (i % 2) == 0);
            check("rr_ack1", ack1, (i % 2) == 1);
            if (i > 0) begin
                check("rr_ld", ld, ((i % 2) == 1) ? 8'h02 : 8'h04);
                check("rr_din", din, ((i % 2) == 1) ? 16'hA000 + 16'(i - 1) : 16'hB000 + 16'(i - 1));
            end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("rr_ld_last", ld, 8'h04);
        check("rr_din_last", din, 16'hB003);
        tick();
        check("rr_ld_off", ld, 8'h00);

        // read hazard on the register being loaded
        req0 = 1'b1; addr0 = 3'd5; data0 = 16'h5555;
        #1;
        $display("[TB] txn hazard write addr=5");
        check("hz_ack0", ack0, 1'b1);
        tick();
        req0 = 1'b0; selA = 3'd5; rdA_en = 1'b1; selB = 3'd3; rdB_en = 1'b1;
        #1;
        check("hz_ld", ld, 8'h20);
        check("hz_oeA", oeA, 8'h20);
        check("hz_hazA", hazA, 1'b1);
        check("hz_oeB", oeB, 8'h08);
        check("hz_hazB", hazB, 1'b0);
        tick();
        check("hz_hazA_off", hazA, 1'b0);
        check("hz_oeA_hold", oeA, 8'h20);
        rdA_en = 1'b0; rdB_en = 1'b0;
        #1;
        check("hz_oeA_dis", oeA, 8'h00);
        check("hz_oeB_dis", oeB, 8'h00);

        // clear walk with req1 held off until IDLE, clr re-pulsed mid-walk
        clr = 1'b1;
        #1;
        $display("[TB] txn clear start");
        check("cl_busy_pre", busy, 1'b0);
        tick();
        clr = 1'b0; req1 = 1'b1; addr1 = 3'd7; data1 = 16'h7777;
        for (int k = 0; k < 8; k++) begin
            clr = (k == 3);
            #1;
            check("cl_busy", busy, 1'b1);
            check("cl_ld", ld, 8'h01 << k);
            check("cl_din", din, 16'h0);
            check("cl_ack1", ack1, 1'b0);
            check("cl_done", clr_done, 1'b0);
            tick();
        end
        clr = 1'b0;
        #1;
        check("cl_busy_end", busy, 1'b0);
        check("cl_done_pulse", clr_done, 1'b1);
        check("cl_ack1_end", ack1, 1'b1);
        check("cl_ld_end", ld, 8'h00);
        tick();
        req1 = 1'b0;
        #1;
        check("cl_r1_ld", ld, 8'h80);
        check("cl_r1_din", din, 16'h7777);
        check("cl_done_off", clr_done, 1'b0);
        tick();

        // transfer accepted on the clr edge drains before the walk
        req0 = 1'b1; addr0 = 3'd2; data0 = 16'h2222; clr = 1'b1;
        #1;
        $display("[TB] txn clear with concurrent write");
        check("cw_ack0", ack0, 1'b1);
        tick();
        req0 = 1'b0; clr = 1'b0;
        #1;
        check("cw_busy", busy, 1'b1);
        check("cw_ld", ld, 8'h04);
        check("cw_din", din, 16'h2222);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("cw_walk_ld", ld, 8'h01 << k);
            check("cw_walk_busy", busy, 1'b1);
            tick();
        end
        check("cw_busy_end", busy, 1'b0);
        check("cw_done", clr_done, 1'b1);
        tick();
        check("cw_done_off", clr_done, 1'b0);

        // reset mid-clear at k=4
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick(); tick(); tick();
        $display("[TB] txn reset during clear");
        check("ra_ld_k4", ld, 8'h10);
        req0 = 1'b1; req1 = 1'b1; selA = 3'd4; rdA_en = 1'b1;
        reset = 1'b1;
        #1;
        check("ra_ld", ld, 8'h00);
        check("ra_din", din, 16'h0);
        check("ra_busy", busy, 1'b0);
        check("ra_ack0", ack0, 1'b0);
        check("ra_ack1", ack1, 1'b0);
        check("ra_oeA", oeA, 8'h00);
        check("ra_hazA", hazA, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("ra_ptr_ack0", ack0, 1'b1);
        check("ra_ptr_ack1", ack1, 1'b0);
        check("ra_busy_rel", busy, 1'b0);
        req0 = 1'b0; req1 = 1'b0; rdA_en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        check("ra_restart_ld", ld, 8'h01);
        check("ra_restart_busy", busy, 1'b1);
        tick();
        check("ra_restart_ld1", ld, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
